// File: rtl/pause_access_ctrl_if.sv
// pause_access_ctrl_if: groups the pause/OSD controls, both work-RAM requesters
// and the muxed RAM port, with the status outputs of the controller.
`default_nettype none

interface pause_access_ctrl_if;
  logic        btn_pause;
  logic        osd_open;
  logic        osd_pause_en;
  logic        hs_req;
  logic [15:0] hs_addr;
  logic        hs_we;
  logic [7:0]  hs_din;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_din;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic        hs_grant;
  logic        cpu_pause;
  logic        dim;

  modport slave (
    input  btn_pause, osd_open, osd_pause_en,
    input  hs_req, hs_addr, hs_we, hs_din,
    input  cpu_addr, cpu_we, cpu_din,
    output ram_addr, ram_we, ram_din,
    output hs_grant, cpu_pause, dim
  );

  modport master (
    output btn_pause, osd_open, osd_pause_en,
    output hs_req, hs_addr, hs_we, hs_din,
    output cpu_addr, cpu_we, cpu_din,
    input  ram_addr, ram_we, ram_din,
    input  hs_grant, cpu_pause, dim
  );
endinterface

`default_nettype wire

// File: rtl/pause_access_ctrl.sv
// pause_access_ctrl: halts the game CPU for user/OSD pause or hiscore access,
// arbitrates the work-RAM port and dims video after a long pause.
`default_nettype none

module pause_access_ctrl #(
  parameter int          SETTLE     = 4,
  parameter logic [31:0] DIM_CYCLES = 32'h1C9C3800
) (
  input  logic                clk_sys,
  input  logic                reset,
  pause_access_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] c_SETTLE_LD = 8'(SETTLE - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_settle;
  logic [31:0] r_dim_cnt;
  logic        r_hs_grant;
  logic        r_cpu_pause;
  logic        r_user_pause;
  logic        r_btn_prev;
  logic        w_btn_edge;
  logic        w_user_pause_nxt;
  logic        w_hs_sel;

  assign w_btn_edge       = bus.btn_pause & ~r_btn_prev;
  assign w_user_pause_nxt = r_user_pause ^ w_btn_edge;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (bus.hs_req) w_state_nxt = DRAIN;
      DRAIN:   if (!bus.hs_req) w_state_nxt = RUN;
               else if (r_settle == 8'd0) w_state_nxt = GRANT;
      GRANT:   if (!bus.hs_req) w_state_nxt = RELEASE;
      RELEASE: w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // Outputs are registered from the next state so cpu_pause rises on the
  // same edge that leaves RUN, and hs_grant on the edge that enters GRANT.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= RUN;
      r_settle     <= 8'd0;
      r_dim_cnt    <= 32'd0;
      r_hs_grant   <= 1'b0;
      r_cpu_pause  <= 1'b0;
      r_user_pause <= 1'b0;
      r_btn_prev   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_btn_prev   <= bus.btn_pause;
      r_user_pause <= w_user_pause_nxt;
      r_hs_grant   <= (w_state_nxt == GRANT);
      r_cpu_pause  <= w_user_pause_nxt | (bus.osd_open & bus.osd_pause_en)
                      | (w_state_nxt != RUN);

      if (r_state == RUN && bus.hs_req)
        r_settle <= c_SETTLE_LD;
      else if (r_state == DRAIN && r_settle != 8'd0)
        r_settle <= r_settle - 8'd1;

      if (!r_cpu_pause)
        r_dim_cnt <= 32'd0;
      else if (r_dim_cnt < DIM_CYCLES)
        r_dim_cnt <= r_dim_cnt + 32'd1;
    end
  end

  // Reset forces the port back to the CPU in the same cycle it is asserted.
  assign w_hs_sel      = r_hs_grant & ~reset;
  assign bus.ram_addr  = w_hs_sel ? bus.hs_addr : bus.cpu_addr;
  assign bus.ram_we    = w_hs_sel ? bus.hs_we   : bus.cpu_we;
  assign bus.ram_din   = w_hs_sel ? bus.hs_din  : bus.cpu_din;
  assign bus.hs_grant  = r_hs_grant;
  assign bus.cpu_pause = r_cpu_pause;
  assign bus.dim       = (r_dim_cnt >= DIM_CYCLES) & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_pause_access_ctrl.sv
// tb_pause_access_ctrl: vector tables for the RAM mux plus hand-written
// sequences for arbitration latency, abort, release, pause/dim and reset.
`default_nettype none

module tb_pause_access_ctrl;
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_sys = ~clk_sys;

  pause_access_ctrl_if bus ();

  pause_access_ctrl #(.SETTLE(4), .DIM_CYCLES(32'd16)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] hs_addr;
    logic        hs_we;
    logic [7:0]  hs_din;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_din;
    logic [15:0] e_addr;
    logic        e_we;
    logic [7:0]  e_din;
  } vec_t;

  vec_t run_vec[3];
  vec_t grant_vec[3];

  task automatic expect_v(input string n, input logic [31:0] e);
    exp_t x;
    x.name = n;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic check_v(input logic [31:0] act);
    exp_t x;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got %h with no expectation", act);
    end else begin
      x = sb.pop_front();
      if (act !== x.exp) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", x.name, act, x.exp);
      end
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    bus.hs_addr  = v.hs_addr;
    bus.hs_we    = v.hs_we;
    bus.hs_din   = v.hs_din;
    bus.cpu_addr = v.cpu_addr;
    bus.cpu_we   = v.cpu_we;
    bus.cpu_din  = v.cpu_din;
    expect_v({tag, "_addr"}, {16'd0, v.e_addr});
    expect_v({tag, "_we"},   {31'd0, v.e_we});
    expect_v({tag, "_din"},  {24'd0, v.e_din});
    #1;
    check_v({16'd0, bus.ram_addr});
    check_v({31'd0, bus.ram_we});
    check_v({24'd0, bus.ram_din});
  endtask

  initial begin
    run_vec[0]   = '{16'h1111, 1'b1, 8'h11, 16'h2222, 1'b0, 8'h22, 16'h2222, 1'b0, 8'h22};
    run_vec[1]   = '{16'hAAAA, 1'b0, 8'hAA, 16'h5555, 1'b1, 8'h55, 16'h5555, 1'b1, 8'h55};
    run_vec[2]   = '{16'hFFFF, 1'b1, 8'hFF, 16'h0000, 1'b1, 8'h00, 16'h0000, 1'b1, 8'h00};
    grant_vec[0] = '{16'h1234, 1'b1, 8'hA5, 16'h4321, 1'b1, 8'h5A, 16'h1234, 1'b1, 8'hA5};
    grant_vec[1] = '{16'h0F0F, 1'b0, 8'h3C, 16'hF0F0, 1'b1, 8'hC3, 16'h0F0F, 1'b0, 8'h3C};
    grant_vec[2] = '{16'h8001, 1'b1, 8'h01, 16'h7FFE, 1'b0, 8'hFE, 16'h8001, 1'b1, 8'h01};

    bus.btn_pause = 0; bus.osd_open = 0; bus.osd_pause_en = 0;
    bus.hs_req = 0; bus.hs_addr = 16'h1234; bus.hs_we = 1; bus.hs_din = 8'hA5;
    bus.cpu_addr = 16'hBEEF; bus.cpu_we = 0; bus.cpu_din = 8'h77;
    reset = 1;
    tick(3);
    expect_v("rst_hs_grant", 0);  check_v({31'd0, bus.hs_grant});
    expect_v("rst_cpu_pause", 0); check_v({31'd0, bus.cpu_pause});
    expect_v("rst_dim", 0);       check_v({31'd0, bus.dim});
    expect_v("rst_ram_addr", 32'h0000BEEF); check_v({16'd0, bus.ram_addr});
    expect_v("rst_ram_we", 0);    check_v({31'd0, bus.ram_we});
    reset = 0;
    tick(2);

    for (int i = 0; i < 3; i++) apply_vec(run_vec[i], $sformatf("run%0d", i));

    // Arbitration latency: grant exactly SETTLE+1 edges after hs_req sampled.
    bus.hs_req = 1;
    tick();
    expect_v("lat_cpu_pause", 1); check_v({31'd0, bus.cpu_pause});
    for (int i = 2; i <= 5; i++) begin
      tick();
      expect_v($sformatf("lat_grant_e%0d", i), (i == 5) ? 1 : 0);
      check_v({31'd0, bus.hs_grant});
    end

    for (int i = 0; i < 3; i++) apply_vec(grant_vec[i], $sformatf("grant%0d", i));

    // Release lasts one cycle; hs_req raised there must not re-arbitrate early.
    bus.hs_req = 0;
    bus.cpu_addr = 16'hC0DE;
    tick();
    expect_v("rel_hs_grant", 0);  check_v({31'd0, bus.hs_grant});
    expect_v("rel_cpu_pause", 1); check_v({31'd0, bus.cpu_pause});
    expect_v("rel_ram_addr", 32'h0000C0DE); check_v({16'd0, bus.ram_addr});
    bus.hs_req = 1;
    tick();
    expect_v("rel_run_cpu_pause", 0); check_v({31'd0, bus.cpu_pause});
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_v($sformatf("rearb_grant_e%0d", i), (i == 5) ? 1 : 0);
      check_v({31'd0, bus.hs_grant});
    end
    bus.hs_req = 0;
    tick(3);

    // Abort in DRAIN.
    bus.hs_req = 1;
    tick(3);
    expect_v("abort_grant_mid", 0); check_v({31'd0, bus.hs_grant});
    bus.hs_req = 0;
    tick();
    expect_v("abort_cpu_pause", 0); check_v({31'd0, bus.cpu_pause});
    tick(4);
    expect_v("abort_grant_late", 0); check_v({31'd0, bus.hs_grant});

    // OSD pause gating.
    bus.osd_open = 1;
    tick();
    expect_v("osd_noen_pause", 0); check_v({31'd0, bus.cpu_pause});
    bus.osd_pause_en = 1;
    #1;
    expect_v("osd_en_before_edge", 0); check_v({31'd0, bus.cpu_pause});
    tick();
    expect_v("osd_en_pause", 1); check_v({31'd0, bus.cpu_pause});
    bus.osd_open = 0; bus.osd_pause_en = 0;
    tick(2);

    // Held button: single toggle, dim after 16 paused cycles.
    bus.btn_pause = 1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1)  begin expect_v("btn_pause_on", 1);  check_v({31'd0, bus.cpu_pause}); end
      if (i == 16) begin expect_v("dim_before", 0);    check_v({31'd0, bus.dim}); end
      if (i == 17) begin expect_v("dim_after", 1);     check_v({31'd0, bus.dim}); end
      if (i == 40) begin
        expect_v("btn_single_toggle", 1); check_v({31'd0, bus.cpu_pause});
        expect_v("dim_held", 1);          check_v({31'd0, bus.dim});
      end
    end
    bus.btn_pause = 0;
    tick(2);
    bus.btn_pause = 1;
    tick();
    expect_v("btn2_pause_off", 0); check_v({31'd0, bus.cpu_pause});
    tick();
    expect_v("btn2_dim_off", 0); check_v({31'd0, bus.dim});
    bus.btn_pause = 0;
    tick();

    // Reset during GRANT with user pause active.
    bus.btn_pause = 1;
    tick();
    bus.btn_pause = 0;
    bus.hs_req = 1;
    tick(5);
    expect_v("pre_rst_grant", 1); check_v({31'd0, bus.hs_grant});
    bus.hs_addr = 16'h1234; bus.cpu_addr = 16'h5678;
    reset = 1;
    #1;
    expect_v("rst_same_cycle_addr", 32'h00005678); check_v({16'd0, bus.ram_addr});
    tick();
    expect_v("rstg_hs_grant", 0);  check_v({31'd0, bus.hs_grant});
    expect_v("rstg_cpu_pause", 0); check_v({31'd0, bus.cpu_pause});
    expect_v("rstg_dim", 0);       check_v({31'd0, bus.dim});
    expect_v("rstg_ram_addr", 32'h00005678); check_v({16'd0, bus.ram_addr});
    reset = 0;
    bus.hs_req = 0;
    tick();
    expect_v("post_rst_user_pause", 0); check_v({31'd0, bus.cpu_pause});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
